// File: rtl/pci_target_burst.sv
// PCI memory target: claims a BASE_ADDR window and serves linear burst reads/writes
// from a DEPTH x 32 word array, with STOP disconnect at the window end or optional wrap.
module pci_target_burst #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 16,
  parameter bit          WRAP      = 1'b0,
  parameter logic [3:0]  READ_CMD  = 4'b0110,
  parameter logic [3:0]  WRITE_CMD = 4'b0111
) (
  input  logic        CLK,
  input  logic        RST,
  inout  tri   [31:0] ADDR_DATA,
  input  logic [3:0]  C_BE,
  input  logic        FRAME,
  input  logic        IRDY,
  output logic        TRDY,
  output logic        DEVSEL,
  output logic        STOP
);

  localparam int AW = $clog2(DEPTH);
  localparam int WB = AW + 2;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_TURN, S_READ, S_WRITE, S_DISC, S_BACKOFF
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   ptr_reg, ptr_next;
  logic            is_write_reg, is_write_next;
  logic            frame_prev_reg;
  logic [31:0]     rd_data_reg;
  logic [31:0]     mem [0:DEPTH-1];

  logic            addr_phase;
  logic            hit;
  logic            xfer;
  logic            at_end;
  logic            drive_en;
  logic [3:0]      lane_we;

  // Only a genuine FRAME falling edge seen while idle starts a claim attempt.
  assign addr_phase = (state_reg == S_IDLE) && !FRAME && frame_prev_reg;
  assign hit        = (ADDR_DATA[31:WB] == BASE_ADDR[31:WB]) &&
                      (ADDR_DATA[1:0] == 2'b00) &&
                      ((C_BE == READ_CMD) || (C_BE == WRITE_CMD));
  assign xfer       = ((state_reg == S_READ) || (state_reg == S_WRITE)) && !IRDY;
  assign at_end     = (ptr_reg == LAST_WORD);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = xfer && (state_reg == S_WRITE) && !C_BE[gi];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= '0;
      is_write_reg   <= 1'b0;
      frame_prev_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      is_write_reg   <= is_write_next;
      frame_prev_reg <= FRAME;
    end
  end

  // Array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[ptr_reg][8*i +: 8] <= ADDR_DATA[8*i +: 8];
      end
    end
    if (state_next == S_READ) begin
      rd_data_reg <= mem[ptr_next];
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    is_write_next = is_write_reg;
    case (state_reg)
      S_IDLE: begin
        if (addr_phase) begin
          ptr_next      = ADDR_DATA[WB-1:2];
          is_write_next = (C_BE == WRITE_CMD);
          if (hit) begin
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: state_next = is_write_reg ? S_WRITE : S_TURN;
      S_TURN:   state_next = S_READ;
      S_READ, S_WRITE: begin
        if (xfer) begin
          ptr_next = ptr_reg + AW'(1);
          if (FRAME) begin
            state_next = S_BACKOFF;
          end else if (at_end && !WRAP) begin
            state_next = S_DISC;
          end
        end
      end
      S_DISC: begin
        if (FRAME) begin
          state_next = S_BACKOFF;
        end
      end
      S_BACKOFF: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    TRDY     = 1'b1;
    DEVSEL   = 1'b1;
    STOP     = 1'b1;
    drive_en = 1'b0;
    case (state_reg)
      S_TURN: DEVSEL = 1'b0;
      S_READ, S_WRITE: begin
        DEVSEL   = 1'b0;
        TRDY     = 1'b0;
        drive_en = (state_reg == S_READ);
        // Last word of the window with more data wanted: disconnect with data.
        if (at_end && !FRAME && !WRAP) begin
          STOP = 1'b0;
        end
      end
      S_DISC: begin
        DEVSEL = 1'b0;
        STOP   = 1'b0;
      end
      default: ;
    endcase
  end

  assign ADDR_DATA = drive_en ? rd_data_reg : {32{1'bz}};

endmodule

// File: tb/tb_pci_target_burst.sv
// Bench for pci_target_burst: two targets on one bus (WRAP=0 at 0x1000_0000, WRAP=1 at
// 0x2000_0000), a vector table of single-phase transactions plus burst/disconnect/reset sequences.
module tb_pci_target_burst;

  localparam logic [3:0] CMD_RD = 4'b0110;
  localparam logic [3:0] CMD_WR = 4'b0111;
  localparam int NV = 18;

  logic        CLK = 1'b0;
  logic        RST;
  tri1  [31:0] ADDR_DATA;
  logic [31:0] ad_drv;
  logic        ad_en;
  logic [3:0]  C_BE;
  logic        FRAME;
  logic        IRDY;
  logic        trdy0, devsel0, stop0, trdy1, devsel1, stop1;
  logic        trdy, devsel, stop;

  assign ADDR_DATA = ad_en ? ad_drv : {32{1'bz}};
  assign trdy   = trdy0 & trdy1;
  assign devsel = devsel0 & devsel1;
  assign stop   = stop0 & stop1;

  always #5 CLK = ~CLK;

  pci_target_burst #(.BASE_ADDR(32'h1000_0000), .DEPTH(16), .WRAP(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .ADDR_DATA(ADDR_DATA), .C_BE(C_BE), .FRAME(FRAME),
    .IRDY(IRDY), .TRDY(trdy0), .DEVSEL(devsel0), .STOP(stop0)
  );

  pci_target_burst #(.BASE_ADDR(32'h2000_0000), .DEPTH(16), .WRAP(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .ADDR_DATA(ADDR_DATA), .C_BE(C_BE), .FRAME(FRAME),
    .IRDY(IRDY), .TRDY(trdy1), .DEVSEL(devsel1), .STOP(stop1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          claim;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [0:NV-1];

  int tests = 0;
  int fails = 0;

  logic [31:0] wdat     [0:7];
  logic [3:0]  wbe      [0:7];
  int          wait_pre [0:7];
  logic [31:0] rdat     [0:7];
  logic [31:0] hold_dat [0:7];
  int          n_xfer, first_lat, stop_k;
  bit          claimed, disc, out_low, bus_drv;
  logic        post_trdy, post_devsel, post_stop;
  logic [31:0] post_ad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < 8; i++) begin
      wdat[i] = '0; wbe[i] = '0; wait_pre[i] = 0; rdat[i] = '0; hold_dat[i] = '0;
    end
  endtask

  // Initiator model: address phase, then n data phases with optional IRDY waits.
  // Returns at the negedge after the final transfer; on a disconnect FRAME is left low.
  task automatic run_burst(input logic [31:0] addr, input logic [3:0] cmd, input int n);
    bit wr;
    int k, waitc, cyc;
    wr = (cmd == CMD_WR);
    k = 0; waitc = 0; cyc = 0;
    claimed = 0; disc = 0; out_low = 0; bus_drv = 0; first_lat = -1; stop_k = -1;
    @(negedge CLK);
    FRAME = 1'b0; IRDY = 1'b1; C_BE = cmd; ad_drv = addr; ad_en = 1'b1;
    @(negedge CLK);
    cyc = 1;
    ad_en = wr;
    while (k < n && cyc < 40) begin
      IRDY   = (waitc < wait_pre[k]);
      FRAME  = (k == n - 1) && !IRDY;
      C_BE   = wr ? wbe[k] : 4'h0;
      ad_drv = wdat[k];
      #1;
      if (!devsel) claimed = 1;
      if (!claimed) begin
        if (!trdy || !stop) out_low = 1;
        if (!wr && ADDR_DATA !== 32'hFFFF_FFFF) bus_drv = 1;
      end
      if (!IRDY && !trdy) begin
        if (first_lat < 0) first_lat = cyc;
        rdat[k] = ADDR_DATA;
        if (!stop) begin
          if (stop_k < 0) stop_k = k;
          disc = 1;
        end
        k++;
        waitc = 0;
      end else if (IRDY) begin
        hold_dat[k] = ADDR_DATA;
        waitc++;
      end
      if (!claimed && cyc >= 5) break;
      @(negedge CLK);
      cyc++;
      if (disc) break;
    end
    n_xfer = k;
    if (!disc) begin
      FRAME = 1'b1; IRDY = 1'b1; ad_en = 1'b0; C_BE = 4'h0;
      #1;
      post_trdy = trdy; post_devsel = devsel; post_stop = stop; post_ad = ADDR_DATA;
    end
    $display("[TB] txn addr=%h cmd=%b n=%0d xfers=%0d claimed=%0b lat=%0d stop_at=%0d rd0=%h",
             addr, cmd, n, n_xfer, claimed, first_lat, stop_k, rdat[0]);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    clear_bufs();
    run_burst(addr, CMD_RD, 1);
    check1({name, "_claim"}, claimed, 1'b1);
    check({name, "_data"}, rdat[0], exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h1000_0008, CMD_WR, 32'hDEAD_BEEF, 4'h0, 1'b1, 32'h0};
    vt[1]  = '{32'h1000_0008, CMD_RD, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{32'h1000_0008, CMD_WR, 32'h1122_3344, 4'hA, 1'b1, 32'h0};
    vt[3]  = '{32'h1000_0008, CMD_RD, 32'h0,         4'h0, 1'b1, 32'hDE22_BE44};
    vt[4]  = '{32'h1000_0008, CMD_WR, 32'h5555_5555, 4'hF, 1'b1, 32'h0};
    vt[5]  = '{32'h1000_0008, CMD_RD, 32'h0,         4'h0, 1'b1, 32'hDE22_BE44};
    vt[6]  = '{32'h1000_003C, CMD_WR, 32'hA5A5_0F0F, 4'h0, 1'b1, 32'h0};
    vt[7]  = '{32'h1000_003C, CMD_RD, 32'h0,         4'h0, 1'b1, 32'hA5A5_0F0F};
    vt[8]  = '{32'h1000_0000, CMD_WR, 32'h0BAD_F00D, 4'h0, 1'b1, 32'h0};
    vt[9]  = '{32'h1000_0004, CMD_WR, 32'h1111_2222, 4'h0, 1'b1, 32'h0};
    vt[10] = '{32'h1000_000C, CMD_WR, 32'h3333_4444, 4'h0, 1'b1, 32'h0};
    vt[11] = '{32'h1000_0040, CMD_RD, 32'h0,         4'h0, 1'b0, 32'h0};
    vt[12] = '{32'h1000_0002, CMD_RD, 32'h0,         4'h0, 1'b0, 32'h0};
    vt[13] = '{32'h1000_0004, 4'b0010, 32'h0,        4'h0, 1'b0, 32'h0};
    vt[14] = '{32'h1000_0040, CMD_WR, 32'h9999_9999, 4'h0, 1'b0, 32'h0};
    vt[15] = '{32'h2000_0004, CMD_WR, 32'h7777_8888, 4'h0, 1'b1, 32'h0};
    vt[16] = '{32'h2000_0004, CMD_RD, 32'h0,         4'h0, 1'b1, 32'h7777_8888};
    vt[17] = '{32'h1000_0004, CMD_RD, 32'h0,         4'h0, 1'b1, 32'h1111_2222};

    RST = 1'b0; FRAME = 1'b1; IRDY = 1'b1; C_BE = 4'h0; ad_drv = '0; ad_en = 1'b0;
    clear_bufs();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check1("rst_trdy", trdy, 1'b1);
    check1("rst_devsel", devsel, 1'b1);
    check1("rst_stop", stop, 1'b1);
    check("rst_bus", ADDR_DATA, 32'hFFFF_FFFF);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < NV; i++) begin
      clear_bufs();
      wdat[0] = vt[i].wdata;
      wbe[0]  = vt[i].be;
      run_burst(vt[i].addr, vt[i].cmd, 1);
      if (vt[i].claim) begin
        check1($sformatf("v%0d_claim", i), claimed, 1'b1);
        check($sformatf("v%0d_lat", i), first_lat, (vt[i].cmd == CMD_WR) ? 32'd2 : 32'd3);
        check($sformatf("v%0d_xfers", i), n_xfer, 32'd1);
        check($sformatf("v%0d_stop_at", i), stop_k, 32'hFFFF_FFFF);
        if (vt[i].cmd == CMD_RD) check($sformatf("v%0d_rdata", i), rdat[0], vt[i].exp_rd);
        check1($sformatf("v%0d_post_devsel", i), post_devsel, 1'b1);
        check1($sformatf("v%0d_post_trdy", i), post_trdy, 1'b1);
        check1($sformatf("v%0d_post_stop", i), post_stop, 1'b1);
        check($sformatf("v%0d_post_bus", i), post_ad, 32'hFFFF_FFFF);
      end else begin
        check1($sformatf("v%0d_miss_claim", i), claimed, 1'b0);
        check1($sformatf("v%0d_miss_outs", i), out_low, 1'b0);
        if (vt[i].cmd != CMD_WR) check1($sformatf("v%0d_miss_bus", i), bus_drv, 1'b0);
      end
    end

    // 4-word read with two IRDY wait states before word 2.
    clear_bufs();
    wait_pre[2] = 2;
    run_burst(32'h1000_0000, CMD_RD, 4);
    check("burst_xfers", n_xfer, 32'd4);
    check("burst_lat", first_lat, 32'd3);
    check("burst_w0", rdat[0], 32'h0BAD_F00D);
    check("burst_w1", rdat[1], 32'h1111_2222);
    check("burst_w2", rdat[2], 32'hDE22_BE44);
    check("burst_w3", rdat[3], 32'h3333_4444);
    check("burst_hold", hold_dat[2], 32'hDE22_BE44);
    check("burst_stop_at", stop_k, 32'hFFFF_FFFF);
    check1("burst_post_devsel", post_devsel, 1'b1);

    // Write burst from word 14 with FRAME held low: disconnect with the word-15 transfer.
    clear_bufs();
    wdat[0] = 32'hC0DE_0014; wdat[1] = 32'hC0DE_0015;
    wdat[2] = 32'hBAD0_0000; wdat[3] = 32'hBAD0_0001;
    run_burst(32'h1000_0038, CMD_WR, 4);
    check1("disc_flag", disc, 1'b1);
    check("disc_xfers", n_xfer, 32'd2);
    check("disc_stop_at", stop_k, 32'd1);
    FRAME = 1'b0; IRDY = 1'b0; ad_drv = wdat[2];
    #1;
    check1("disc_c1_trdy", trdy, 1'b1);
    check1("disc_c1_stop", stop, 1'b0);
    check1("disc_c1_devsel", devsel, 1'b0);
    @(negedge CLK);
    FRAME = 1'b1;
    #1;
    check1("disc_c2_trdy", trdy, 1'b1);
    check1("disc_c2_stop", stop, 1'b0);
    @(negedge CLK);
    IRDY = 1'b1; ad_en = 1'b0;
    #1;
    check1("disc_end_trdy", trdy, 1'b1);
    check1("disc_end_devsel", devsel, 1'b1);
    check1("disc_end_stop", stop, 1'b1);
    rd_check("disc_rd14", 32'h1000_0038, 32'hC0DE_0014);
    rd_check("disc_rd15", 32'h1000_003C, 32'hC0DE_0015);
    rd_check("disc_rd0", 32'h1000_0000, 32'h0BAD_F00D);

    // Same burst on the wrapping target: no STOP, third word lands in word 0.
    clear_bufs();
    wdat[0] = 32'hC1C1_0001; wdat[1] = 32'hC1C1_0002; wdat[2] = 32'hC1C1_0003;
    run_burst(32'h2000_0038, CMD_WR, 3);
    check1("wrap_disc", disc, 1'b0);
    check("wrap_xfers", n_xfer, 32'd3);
    check("wrap_stop_at", stop_k, 32'hFFFF_FFFF);
    rd_check("wrap_rd0", 32'h2000_0000, 32'hC1C1_0003);
    rd_check("wrap_rd15", 32'h2000_003C, 32'hC1C1_0002);
    rd_check("wrap_rd1", 32'h2000_0004, 32'h7777_8888);

    // Asynchronous reset in the middle of a read burst.
    @(negedge CLK);
    FRAME = 1'b0; IRDY = 1'b1; C_BE = CMD_RD; ad_drv = 32'h1000_0000; ad_en = 1'b1;
    @(negedge CLK);
    ad_en = 1'b0; IRDY = 1'b0; C_BE = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("arst_w0", ADDR_DATA, 32'h0BAD_F00D);
    check1("arst_w0_trdy", trdy, 1'b0);
    @(negedge CLK);
    #1;
    check("arst_w1", ADDR_DATA, 32'h1111_2222);
    #2;
    RST = 1'b0;
    #1;
    check1("arst_trdy", trdy, 1'b1);
    check1("arst_devsel", devsel, 1'b1);
    check1("arst_stop", stop, 1'b1);
    check("arst_bus", ADDR_DATA, 32'hFFFF_FFFF);
    $display("[TB] txn async reset asserted mid-read");
    FRAME = 1'b1; IRDY = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    rd_check("arst_after", 32'h1000_0008, 32'hDE22_BE44);
    check("arst_after_lat", first_lat, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pci_target_burst.md
Name: pci_target_burst

Overview:
- Parameterised successor PCI memory target: claims a configurable address window and serves linear burst reads and writes from a local DEPTH x 32 word array.
- Adds over the first-generation target:
  - PCI-standard active-low byte enables
  - STOP-based target disconnect at the window end, or an optional wrap mode
  - single-edge (posedge) timing throughout
- Sits directly on the shared ADDR_DATA bus alongside other targets.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base of the claimed window; must be aligned to 4*DEPTH.
- DEPTH, 16, number of 32-bit words; power of 2, range 2..256.
- WRAP, 0, 0 = disconnect at window end; 1 = pointer wraps to word 0 and the burst continues.
- READ_CMD, 4'b0110, C_BE command code for memory read.
- WRITE_CMD, 4'b0111, C_BE command code for memory write.

Ports:
- CLK  input  1  bus clock; all logic on posedge.
- RST  input  1  asynchronous, active-low reset.
- ADDR_DATA  inout  32  multiplexed address/data; driven only in read data phases.
- C_BE  input  4  command in address phase; active-low byte enables in data phases.
- FRAME  input  1  active-low transaction frame from the initiator.
- IRDY  input  1  active-low initiator ready.
- TRDY  output  1  active-low target ready.
- DEVSEL  output  1  active-low device select.
- STOP  output  1  active-low target stop/disconnect request.

Behaviour:
- Reset (RST low, asynchronous):
  - TRDY = DEVSEL = STOP = 1; ADDR_DATA released to high-Z.
  - state = IDLE, word pointer = 0.
  - Array contents are not reset. Reset asserted mid-transaction aborts it the same way, with no partial state kept.
- Data transfer: occurs at a posedge where IRDY == 0 and TRDY == 0 are both sampled.
- Hit condition:
  - ADDR_DATA[31:$clog2(4*DEPTH)] == BASE_ADDR upper bits
  - ADDR_DATA[1:0] == 2'b00
  - C_BE == READ_CMD or WRITE_CMD
  - Any miss: stay IDLE and never drive anything, so the initiator sees a master abort.
- States:
  - IDLE: on a FRAME high->low transition (FRAME sampled low, previous sample high), latch address and command. Pointer = ADDR_DATA[$clog2(4*DEPTH)-1:2]. Hit -> DECODE, else remain IDLE until FRAME is sampled high.
  - DECODE (1 cycle):
    - Write: DEVSEL = 0 and TRDY = 0 from the next edge; -> WRITE.
    - Read: DEVSEL = 0, TRDY = 1; -> TURN.
  - TURN (read turnaround, 1 cycle): register mem[pointer] onto ADDR_DATA, enable the driver, TRDY = 0; -> READ. First read data is valid 3 clocks after the address edge.
  - READ:
    - On a transfer: pointer += 1; the next word is registered onto ADDR_DATA for the next cycle.
    - IRDY high: hold data and pointer, no increment (wait state).
  - WRITE:
    - On a transfer: for each i, if C_BE[i] == 0, write mem[pointer][8i+7:8i] = ADDR_DATA[8i+7:8i]; then pointer += 1.
    - C_BE == 4'hF: the data phase completes with no write.
  - Last phase: a transfer with FRAME sampled high -> BACKOFF.
  - Window end (pointer == DEPTH-1 with FRAME low):
    - WRAP = 0: assert STOP = 0 together with TRDY = 0 for this data phase (disconnect with data). After the transfer, TRDY = 1 and STOP held 0; -> DISC.
    - WRAP = 1: pointer wraps to 0 and the burst continues with no STOP.
  - DISC: hold DEVSEL = 0, STOP = 0 until FRAME is sampled high -> BACKOFF. No further transfers are accepted.
  - BACKOFF (1 cycle): TRDY = DEVSEL = STOP = 1, ADDR_DATA released; -> IDLE. A new FRAME falling edge is not claimed during this cycle.
- Driver: ADDR_DATA is enabled only in TURN→READ through the last read transfer. It is disabled the cycle after the final transfer, and never in write or idle states.
- Simultaneous window end and FRAME high: normal last phase; -> BACKOFF, no STOP.
- Pointer arithmetic is modulo DEPTH; the address is never incremented outside the window.

Test Plan (BASE_ADDR = 32'h1000_0000, DEPTH = 16, WRAP = 0 unless stated):
- Single write then read:
  - Write addr 32'h1000_0008, cmd 0111, data 32'hDEAD_BEEF, C_BE 4'h0, FRAME high in the first data phase -> DEVSEL/TRDY low one cycle after the address edge, mem[2] = DEAD_BEEF.
  - Read back -> ADDR_DATA = DEAD_BEEF 3 clocks after the address edge, DEVSEL high after completion.
- Byte enables: write 32'h1122_3344 to word 2 with C_BE 4'b1010 -> mem[2] = 32'hDE22_BE44.
- Burst with initiator waits: 4-word read from 32'h1000_0000 with IRDY high for 2 cycles between words 1 and 2 -> words 0..3 delivered in order, data held during the wait, no pointer skip.
- Disconnect:
  - Burst write from word 14 with FRAME held low -> words 14 and 15 written; STOP low with the word-15 TRDY.
  - Next cycle TRDY high, STOP held low until FRAME high, then all deasserted.
  - Same burst with WRAP = 1 -> no STOP; the third word lands in mem[0].
- Misses:
  - Address 32'h1000_0040, address 32'h1000_0002, or cmd 4'b0010 -> DEVSEL/TRDY/STOP stay high and ADDR_DATA is never driven.
- Async reset: RST low mid-burst during a read -> outputs high and bus high-Z immediately, without waiting for a CLK edge. The next transaction after RST high is claimed normally, and previously written words are retained.
